// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - request/response channel bundle for nibble_serial_add_ctrl
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  // Requester side: issues operands, consumes results.
  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
    input  in_ready, out_valid, result, cout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
    output in_ready, out_valid, result, cout
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit adder sequenced over a shared 4-bit adder; optional subtract under SUB_EN
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus,
  output logic                    busy,
  output logic [3:0]              fa_a,
  output logic [3:0]              fa_b,
  output logic                    fa_cin,
  input  logic [3:0]              fa_sum,
  input  logic                    fa_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry;
  logic             cout_reg;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             accept;
  logic             last_step;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (state == RUN) && (idx == IW'(NIB - 1));

`ifdef SUB_EN
  // Subtract as A + ~B + 1; the requester's carry-in is overridden.
  assign b_in   = bus.op_sub ? ~bus.op_b : bus.op_b;
  assign cin_in = bus.op_sub | bus.op_cin;
`else
  logic unused_op_sub;
  assign b_in          = bus.op_b;
  assign cin_in        = bus.op_cin;
  assign unused_op_sub = bus.op_sub;
`endif

  assign bus.result = res_reg;
  assign bus.cout   = cout_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake/adder-drive outputs; adder inputs are zero outside RUN.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    fa_a          = 4'h0;
    fa_b          = 4'h0;
    fa_cin        = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_reg[4*idx +: 4];
        fa_b   = b_reg[4*idx +: 4];
        fa_cin = carry;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-nibble accumulation of the adder's sum and carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.op_a;
      b_reg   <= b_in;
      carry   <= cin_in;
      idx     <= '0;
      res_reg <= '0;
    end else if (state == RUN) begin
      res_reg[4*idx +: 4] <= fa_sum;
      carry               <= fa_cout;
      idx                 <= idx + IW'(1);
      if (last_step) cout_reg <= fa_cout;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench with behavioural 4-bit adder and arithmetic reference model
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [3:0] fa_a, fa_b, fa_sum;
  logic       fa_cin, fa_cout;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) ifc ();

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .busy    (busy),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  // External 4-bit adder.
  assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {4'h0, fa_cin};

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [WIDTH:0] s;
`ifdef SUB_EN
    if (sub) begin
      e.r = a - b;
      e.c = (a >= b);
      return e;
    end
`endif
    s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.r = s[WIDTH-1:0];
    e.c = s[WIDTH];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("result", 32'(ifc.result), 32'(e.r));
        check("cout", 32'(ifc.cout), 32'(e.c));
        check("fa_zero_in_done", {23'h0, fa_a, fa_b, fa_cin}, 32'd0);
      end
    end
  end

  // Issue one request; returns #1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    int n;
    n = 0;
    ifc.op_a = a; ifc.op_b = b; ifc.op_cin = cin; ifc.op_sub = sub;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      check("accept_timeout", 32'(ifc.in_ready), 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.op_a = WIDTH'($urandom); ifc.op_b = WIDTH'($urandom);
    ifc.op_cin = 1'($urandom); ifc.op_sub = 1'($urandom);
  endtask

  // Follow the nibble steps right after acceptance and the rise of out_valid.
  task automatic track(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    logic [WIDTH-1:0] be;
    logic             ce;
    longint           mask, carry_in;
    be = b; ce = cin;
`ifdef SUB_EN
    if (sub) begin be = ~b; ce = 1'b1; end
`endif
    for (int k = 0; k < NIB; k++) begin
      mask     = (64'd1 << (4 * k)) - 1;
      carry_in = ((longint'(a) & mask) + (longint'(be) & mask) + longint'(ce)) >> (4 * k);
      check($sformatf("fa_a_step%0d", k), 32'(fa_a), 32'((a >> (4 * k)) & 4'hF));
      check($sformatf("fa_b_step%0d", k), 32'(fa_b), 32'((be >> (4 * k)) & 4'hF));
      check($sformatf("fa_cin_step%0d", k), 32'(fa_cin), 32'(carry_in));
      check("in_ready_run", 32'(ifc.in_ready), 32'd0);
      check("out_valid_run", 32'(ifc.out_valid), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    check("out_valid_latency", 32'(ifc.out_valid), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
  endtask

  // Wait until every expectation has been consumed; optional random backpressure.
  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      if (rnd) ifc.out_ready = 1'($urandom);
      else     ifc.out_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ifc.out_ready = 1'b1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra, rb;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    ifc.op_a = '0; ifc.op_b = '0; ifc.op_cin = 1'b0; ifc.op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(ifc.result), 32'd0);
    check("rst_cout", 32'(ifc.cout), 32'd0);
    check("rst_fa", {23'h0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed adds with step-level tracking.
    send(16'h1234, 16'h4321, 1'b0, 1'b0); track(16'h1234, 16'h4321, 1'b0, 1'b0); drain(0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); track(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain(0);
    send(16'h00FF, 16'h0000, 1'b1, 1'b0); track(16'h00FF, 16'h0000, 1'b1, 1'b0); drain(0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0); track(16'h8000, 16'h8000, 1'b0, 1'b0); drain(0);
    check("idle_fa_zero", {23'h0, fa_a, fa_b, fa_cin}, 32'd0);

    // Subtract requests (plain adds when the feature is absent).
    send(16'h0005, 16'h0007, 1'b0, 1'b1); track(16'h0005, 16'h0007, 1'b0, 1'b1); drain(0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1); track(16'h0007, 16'h0005, 1'b0, 1'b1); drain(0);

    // Backpressure in DONE with competing requests.
    ifc.out_ready = 1'b0;
    e = model(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !ifc.out_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 6; k++) begin
      ifc.in_valid = 1'b1; ifc.op_a = WIDTH'($urandom); ifc.op_b = WIDTH'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      check("bp_result", 32'(ifc.result), 32'(e.r));
      check("bp_cout", 32'(ifc.cout), 32'(e.c));
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(ifc.in_ready), 32'd1);
    check("bp_release_valid", 32'(ifc.out_valid), 32'd0);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0); track(16'h0F0F, 16'h00F1, 1'b0, 1'b0); drain(0);

    // Asynchronous reset at RUN step 2.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(ifc.result), 32'd0);
    check("mid_rst_fa", {23'h0, fa_a, fa_b, fa_cin}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 16'h0002, 1'b0, 1'b0); track(16'h0001, 16'h0002, 1'b0, 1'b0); drain(0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ra = '1; rb = WIDTH'($urandom_range(0, 3)); end
        1:       begin ra = WIDTH'($urandom); rb = ~ra; end
        default: begin ra = WIDTH'($urandom); rb = WIDTH'($urandom); end
      endcase
      send(ra, rb, 1'($urandom), 1'($urandom));
      drain(1);
    end

    check("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
